vtree_filler: RTL and testbench

- Upstream feeder of the sorter stage tree in the virtual merge tree.
- Buffers one block of 1<<P_LOG records per way, written by the external loader.
- Primes the tree with one record per way, then answers the tree's way-index requests with one record each.
- Flags a way as empty once its block is fully consumed, so the loader refills it.

---
 rtl/vtree_pkg.sv | 27 ++
 rtl/DFIFO.sv | 52 +++++
 rtl/vtree_block_buf.sv | 62 ++++++
 rtl/vtree_filler.sv | 144 ++++++++++++++
 tb/tb_vtree_filler.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vtree_pkg.sv
// vtree_pkg: shared read-state encoding and sizing helpers
// for the virtual merge tree filler.
`ifndef VTREE_BLKW
`define VTREE_BLKW(d, p) ((d) << (p))
`endif

package vtree_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } read_state_t;

  function automatic int unsigned blk_w(
    input int unsigned d,
    input int unsigned p
  );
    return `VTREE_BLKW(d, p);
  endfunction

  function automatic int unsigned n_ways(
    input int unsigned w
  );
    return 1 << w;
  endfunction

endpackage

// File: rtl/DFIFO.sv
// DFIFO: small register FIFO, depth 1<<FIFO_SIZE.
// Simultaneous enq and deq are both honoured even when full.
module DFIFO #(
  parameter int FIFO_SIZE  = 2,
  parameter int FIFO_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enq,
  input  logic                  deq,
  input  logic [FIFO_WIDTH-1:0] din,
  output logic [FIFO_WIDTH-1:0] dot,
  output logic                  emp,
  output logic                  full
);

  localparam int D = 1 << FIFO_SIZE;

  logic [FIFO_WIDTH-1:0] r_mem [D];
  logic [FIFO_SIZE-1:0]  r_head;
  logic [FIFO_SIZE-1:0]  r_tail;
  logic [FIFO_SIZE:0]    r_cnt;
  logic                  w_enq;
  logic                  w_deq;

  assign emp   = (r_cnt == '0);
  assign full  = (r_cnt == (FIFO_SIZE+1)'(D));
  assign w_deq = deq && !emp;
  assign w_enq = enq && (!full || w_deq);
  assign dot   = r_mem[r_head];

  always_ff @(posedge CLK) begin
    if (w_enq) r_mem[r_tail] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/vtree_block_buf.sv
// vtree_block_buf: one block of records per way with a
// valid bit and read pointer per way.
module vtree_block_buf
  import vtree_pkg::*;
#(
  parameter int W_LOG = 3,
  parameter int P_LOG = 3,
  parameter int DATW  = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_wr_en,
  input  logic [W_LOG-1:0]              i_wr_way,
  input  logic [blk_w(DATW, P_LOG)-1:0] i_wr_blk,
  input  logic                          i_rd_en,
  input  logic [W_LOG-1:0]              i_rd_way,
  output logic [DATW-1:0]               o_rd_rec,
  output logic [n_ways(W_LOG)-1:0]      o_valid,
  output logic [n_ways(W_LOG)-1:0]      o_emp
);

  localparam int NW = n_ways(W_LOG);
  localparam int NR = 1 << P_LOG;

  logic [DATW-1:0]  r_mem [NW][NR];
  logic [P_LOG-1:0] r_ptr [NW];
  logic [NW-1:0]    r_valid;
  logic             w_wr;
  logic             w_rd;

  assign w_wr     = i_wr_en && !r_valid[i_wr_way];
  assign w_rd     = i_rd_en && r_valid[i_rd_way];
  assign o_rd_rec = r_mem[i_rd_way][r_ptr[i_rd_way]];
  assign o_valid  = r_valid;
  assign o_emp    = ~r_valid;

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int j = 0; j < NR; j++) begin
        r_mem[i_wr_way][j] <= i_wr_blk[DATW*j +: DATW];
      end
    end
  end

  // a way is never written and read in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
      for (int i = 0; i < NW; i++) r_ptr[i] <= '0;
    end else begin
      if (w_wr) begin
        r_valid[i_wr_way] <= 1'b1;
        r_ptr[i_wr_way]   <= '0;
      end
      if (w_rd) begin
        r_ptr[i_rd_way] <= r_ptr[i_rd_way] + 1'b1;
        if (r_ptr[i_rd_way] == '1) r_valid[i_rd_way] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vtree_filler.sv
// vtree_filler: primes the sorter tree, then serves way requests.
// VTREE_FILLER_ERRCHK_EN builds the sticky protocol error flag.
module vtree_filler
  import vtree_pkg::*;
#(
  parameter int W_LOG  = 3,
  parameter int P_LOG  = 3,
  parameter int Q_SIZE = 2,
  parameter int DATW   = 64,
  parameter int KEYW   = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [blk_w(DATW, P_LOG)-1:0] din,
  input  logic                          dinen,
  input  logic [W_LOG-1:0]              din_idx,
  output logic [n_ways(W_LOG)-1:0]      emp,
  input  logic [W_LOG-1:0]              i_request,
  input  logic                          i_request_valid,
  output logic                          queue_full,
  output logic [DATW-1:0]               dot,
  output logic                          doten,
  output logic [W_LOG-1:0]              dot_idx,
  output logic                          init_done,
  output logic                          err
);

  localparam int NW = n_ways(W_LOG);
  localparam logic [W_LOG-1:0] LAST_W = W_LOG'(NW - 1);

  // keys sit in the low KEYW bits and pass through untouched
  if (KEYW > DATW) begin : g_keyw_gt_datw
  end

  read_state_t      r_state;
  read_state_t      w_state_nx;
  logic [W_LOG-1:0] r_cnt;
  logic [W_LOG-1:0] w_way;
  logic [W_LOG-1:0] w_head;
  logic [NW-1:0]    w_valid;
  logic [DATW-1:0]  w_rec;
  logic             w_serve;
  logic             w_deq;
  logic             w_enq;
  logic             w_qemp;
  logic             w_qfull;

  assign queue_full = w_qfull;
  assign w_enq      = i_request_valid && !w_qfull;

  vtree_block_buf #(
    .W_LOG(W_LOG),
    .P_LOG(P_LOG),
    .DATW (DATW)
  ) u_buf (
    .CLK     (CLK),
    .RST     (RST),
    .i_wr_en (dinen),
    .i_wr_way(din_idx),
    .i_wr_blk(din),
    .i_rd_en (w_serve),
    .i_rd_way(w_way),
    .o_rd_rec(w_rec),
    .o_valid (w_valid),
    .o_emp   (emp)
  );

  DFIFO #(
    .FIFO_SIZE (Q_SIZE),
    .FIFO_WIDTH(W_LOG)
  ) u_rq (
    .CLK (CLK),
    .RST (RST),
    .enq (w_enq),
    .deq (w_deq),
    .din (i_request),
    .dot (w_head),
    .emp (w_qemp),
    .full(w_qfull)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= INIT;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (r_state == INIT && w_serve && r_cnt == LAST_W) begin
      w_state_nx = RUN;
    end
  end

  always_comb begin
    w_serve = 1'b0;
    w_deq   = 1'b0;
    w_way   = r_cnt;
    case (r_state)
      INIT: w_serve = w_valid[r_cnt];
      RUN: begin
        w_way   = w_head;
        w_serve = !w_qemp && w_valid[w_head];
        w_deq   = w_serve;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      init_done <= 1'b0;
      doten     <= 1'b0;
      dot       <= '0;
      dot_idx   <= '0;
    end else begin
      doten <= w_serve;
      if (w_serve) begin
        dot     <= w_rec;
        dot_idx <= w_way;
      end
      if (r_state == INIT && w_serve) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_W) init_done <= 1'b1;
      end
    end
  end

`ifdef VTREE_FILLER_ERRCHK_EN
  logic r_err;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if ((dinen && !emp[din_idx]) ||
                 (i_request_valid && w_qfull)) begin
      r_err <= 1'b1;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vtree_filler.sv
// tb_vtree_filler: scoreboard bench; a per-way record queue model
// predicts every record the filler emits, in order.
module tb_vtree_filler;

  typedef struct {
    logic [2:0]  idx;
    logic [63:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] din = '0;
  logic         dinen = 1'b0;
  logic [2:0]   din_idx = '0;
  logic [7:0]   emp;
  logic [2:0]   i_request = '0;
  logic         i_request_valid = 1'b0;
  logic         queue_full;
  logic [63:0]  dot;
  logic         doten;
  logic [2:0]   dot_idx;
  logic         init_done;
  logic         err;

  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;

  logic [63:0] recq [8][$];
  int          pend [$];
  exp_t        sb   [$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  vtree_filler dut (
    .CLK            (clk),
    .RST            (rst),
    .din            (din),
    .dinen          (dinen),
    .din_idx        (din_idx),
    .emp            (emp),
    .i_request      (i_request),
    .i_request_valid(i_request_valid),
    .queue_full     (queue_full),
    .dot            (dot),
    .doten          (doten),
    .dot_idx        (dot_idx),
    .init_done      (init_done),
    .err            (err)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  // pending requests are served strictly in order, head blocks
  task automatic resolve();
    int   w;
    exp_t e;
    while (pend.size() > 0 && recq[pend[0]].size() > 0) begin
      w = pend.pop_front();
      e.idx = 3'(w);
      e.d   = recq[w].pop_front();
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (doten) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_doten got idx=%0d dot=%h want none",
                 dot_idx, dot);
      end else begin
        mon_e = sb.pop_front();
        chk("dot_idx", 64'(dot_idx), 64'(mon_e.idx));
        chk("dot", dot, mon_e.d);
      end
    end
  end

  function automatic logic [511:0] mk_blk(input logic [31:0] hi,
                                          input int base,
                                          input int step);
    logic [511:0] b;
    for (int j = 0; j < 8; j++) begin
      b[64*j +: 64] = {hi, 32'(base + step * j)};
    end
    return b;
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] b;
    for (int j = 0; j < 8; j++) b[64*j +: 64] = {$urandom, $urandom};
    return b;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 8; w++) recq[w].delete();
    pend.delete();
    sb.delete();
    for (int w = 0; w < 8; w++) pend.push_back(w);
    exp_err = 1'b0;
  endtask

  task automatic wr(input int w, input logic [511:0] b);
    din     = b;
    din_idx = 3'(w);
    dinen   = 1'b1;
    if (recq[w].size() == 0) begin
      for (int j = 0; j < 8; j++) recq[w].push_back(b[64*j +: 64]);
      resolve();
    end else begin
`ifdef VTREE_FILLER_ERRCHK_EN
      exp_err = 1'b1;
`endif
    end
    @(negedge clk);
    dinen = 1'b0;
  endtask

  task automatic req(input int w);
    int n = 0;
    while (queue_full && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (queue_full) begin
      checks++;
      errors++;
      $display("FAIL req_timeout got full=1 want full=0 way=%0d", w);
    end else begin
      i_request       = 3'(w);
      i_request_valid = 1'b1;
      pend.push_back(w);
      resolve();
      @(negedge clk);
      i_request_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got pending=%0d want 0", sb.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_emp();
    logic [7:0] e;
    for (int w = 0; w < 8; w++) e[w] = (recq[w].size() == 0);
    chk("emp", 64'(emp), 64'(e));
  endtask

  task automatic drain(input int w);
    while (recq[w].size() > 0) req(w);
  endtask

  task automatic wait_key(input int w, input int key);
    int  n = 0;
    bit  hit = 0;
    while (!hit && n < 200) begin
      if (doten && dot_idx == 3'(w) && dot[31:0] == 32'(key)) hit = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("key_seen", 64'(hit), 64'd1);
  endtask

  task automatic prime_check();
    int  t [8];
    int  n = 0;
    bit  done = 0;
    while (!done && n < 100) begin
      if (doten) begin
        t[dot_idx] = n;
        if (dot_idx == 3'd0) chk("init_done_early", 64'(init_done), 0);
        if (dot_idx == 3'd7) done = 1;
      end
      if (!done) begin
        @(negedge clk);
        n++;
      end
    end
    chk("prime_seen", 64'(done), 64'd1);
    chk("prime_span", 64'(t[7] - t[0]), 64'd7);
    @(negedge clk);
    chk("init_done", 64'(init_done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] b;
    int           perm [8];
    int           w;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_emp", 64'(emp), 64'hff);
    chk("rst_doten", 64'(doten), 0);
    chk("rst_dot", dot, 0);
    chk("rst_init_done", 64'(init_done), 0);
    chk("rst_queue_full", 64'(queue_full), 0);
    chk("rst_err", 64'(err), 0);

    for (int i = 7; i >= 0; i--) begin
      wr(i, mk_blk(32'hC0DE0000 | 32'(i), i + 1, 8));
    end
    prime_check();
    wait_idle();
    check_emp();

    drain(3);
    wait_key(3, 60);
    @(negedge clk);
    chk("emp3_after_last", 64'(emp[3]), 64'd1);
    wait_idle();
    wr(3, rnd_blk());
    chk("emp3_after_refill", 64'(emp[3]), 64'd0);
    wait_idle();

    drain(5);
    wait_idle();
    chk("emp5_drained", 64'(emp[5]), 64'd1);
    req(5);
    req(2);
    begin
      int seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (doten) seen++;
      end
      chk("stall_no_doten", 64'(seen), 0);
    end
    wr(5, mk_blk(32'h55550000, 70, 8));
    wait_idle();
    check_emp();

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 12; k++) begin
        w = $urandom_range(0, 7);
        if (recq[w].size() > 0) req(w);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      check_emp();
      for (int i = 0; i < 8; i++) begin
        if (recq[i].size() == 0) wr(i, rnd_blk());
      end
      wait_idle();
    end

    for (int i = 0; i < 8; i++) drain(i);
    wait_idle();
    check_emp();
    chk("err_clean", 64'(err), 64'(exp_err));
    for (int k = 0; k < 4; k++) req(0);
    chk("queue_full_4", 64'(queue_full), 64'd1);
    i_request       = 3'd0;
    i_request_valid = 1'b1;
`ifdef VTREE_FILLER_ERRCHK_EN
    exp_err = 1'b1;
`endif
    @(negedge clk);
    i_request_valid = 1'b0;
    chk("queue_full_5", 64'(queue_full), 64'd1);
    chk("err_full", 64'(err), 64'(exp_err));
    wr(0, rnd_blk());
    wait_idle();
    chk("queue_drained", 64'(queue_full), 64'd0);

    for (int i = 1; i < 8; i++) wr(i, rnd_blk());
    wait_idle();
    check_emp();
    wr(1, mk_blk(32'hBAD00000, 900, 1));
    @(negedge clk);
    chk("err_ignored_wr", 64'(err), 64'(exp_err));
    req(1);
    req(1);
    wait_idle();

    drain(6);
    wait_idle();
    req(6);
    req(6);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_emp", 64'(emp), 64'hff);
    chk("mid_rst_doten", 64'(doten), 0);
    chk("mid_rst_init_done", 64'(init_done), 0);
    chk("mid_rst_queue_full", 64'(queue_full), 0);
    chk("mid_rst_err", 64'(err), 0);

    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      int j;
      int tmp;
      j = $urandom_range(0, i);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 8; i++) wr(perm[i], rnd_blk());
    wait_idle();
    chk("reprime_done", 64'(init_done), 64'd1);
    for (int k = 0; k < 10; k++) req($urandom_range(0, 7));
    wait_idle();
    check_emp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
